seg_scan_driver: RTL

- Time-multiplexed multi-digit 7-segment display driver; successor to the single-digit combinational hex decoder.
- Holds NUM_DIGITS hex nibbles, per-digit decimal points and blank masks in shadow registers.
- Scans one digit per refresh slot, with anti-ghosting guard cycles and a frame-complete pulse.
- Sits between CPU/peripheral output registers and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_hex_lut.sv | 19 +
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment pattern table for the scanned
// 7-segment display driver. Segment order is bit6=a ... bit0=g, active-low.
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational nibble to active-low segment pattern lookup.
module seg_hex_lut
    import seg_pkg::*;
(
    input  nibble_t nib,
    output seg_t    seg
);

    // Table lookup; anything not matched falls back to all segments dark.
    always_comb begin
        seg = SEG_BLANK;
        for (int k = 0; k < 16; k++) begin
            if (nib == nibble_t'(k)) begin
                seg = HEX_TABLE[k];
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver for common-anode displays.
// One digit is driven per refresh slot; the first GUARD_CYCLES of each slot
// keep every anode off so the previous digit's pattern does not ghost.
// All pins are registered.
// Optional build macro: SEG_LZ_BLANK_EN adds leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   dark;
    logic [NUM_DIGITS-1:0]   an_next;
    nibble_t                 sel_nib;
    logic                    sel_dp;
    logic                    sel_dark;
    seg_t                    lut_seg;
    logic                    in_guard;
    logic                    frame_end;

    // Slot prescaler and digit index; idx steps when the slot counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow registers; a load replaces all three fields at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (i_load) begin
            data_q  <= i_data;
            dp_q    <= i_dp;
            blank_q <= i_blank;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // A digit is suppressed while it and every digit above it are zero;
    // digit 0 always stays visible so a zero value still shows "0".
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run        = run & (data_q[4*k +: 4] == 4'h0);
            lz_mask[k] = run;
        end
    end

    assign dark = blank_q | lz_mask;
`else
    assign dark = blank_q;
`endif

    // Select the shadow fields of the digit currently being scanned.
    always_comb begin
        sel_nib  = '0;
        sel_dp   = 1'b0;
        sel_dark = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_nib  = data_q[4*k +: 4];
                sel_dp   = dp_q[k];
                sel_dark = dark[k];
            end
        end
    end

    seg_hex_lut u_lut (
        .nib (sel_nib),
        .seg (lut_seg)
    );

    assign in_guard  = (int'(cnt) < GUARD_CYCLES);
    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Anode enables: all off during guard, otherwise only the current digit.
    always_comb begin
        an_next = '1;
        if (!in_guard) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    an_next[k] = 1'b0;
                end
            end
        end
    end

    // Output pin register; segments keep updating during guard, only anodes are held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg   <= SEG_BLANK;
            o_dp    <= 1'b1;
            o_an    <= '1;
            o_frame <= 1'b0;
        end else begin
            o_seg   <= sel_dark ? SEG_BLANK : lut_seg;
            o_dp    <= sel_dark | ~sel_dp;
            o_an    <= an_next;
            o_frame <= frame_end;
        end
    end

endmodule
